// File: rtl/tty_rx_fifo.sv
// Oversampled async serial receiver feeding a small tagged FIFO, read through positive-I/O-bus IOT strobes.
// Words are pushed on the last stop sample; the head is visible combinationally while iot_sel & iot_rd.
module tty_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int STOP_BITS  = 2,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 ser_in,
  input  logic                 io_clr,
  input  logic                 iot_sel,
  input  logic                 iot_skp,
  input  logic                 iot_rd,
  input  logic                 iot_clr_flag,
  input  logic                 iot_clr_err,
  input  logic                 iot_rdr_run,
  output logic [DATA_BITS-1:0] data_out,
  output logic [2:0]           err_out,
  output logic                 flag,
  output logic                 skip,
  output logic                 active,
  output logic                 reader_run,
  output logic                 overrun
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = DATA_BITS + 2;
  localparam logic [CW-1:0] HALF_CNT = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_CNT  = CW'(OVERSAMPLE - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic                 clr;
  logic                 sync1, s_in;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [3:0]           nbits;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 pe_r, fe_r, wait_mark;
  logic                 tick_due, start_ok, push, fe_now;

  logic [WW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 full, pop, wr_en, ovr_set, rd_gate;
  logic [WW-1:0]        head;

  assign clr      = rst | io_clr;
  assign tick_due = baud_tick & (cnt == '0);
  assign start_ok = (state == S_START) & tick_due & ~s_in;
  assign push     = (state == S_STOP) & tick_due & (stop_idx == 1'(STOP_BITS - 1));
  assign fe_now   = fe_r | ~s_in;

  always_ff @(posedge clk) begin
    if (clr) {sync1, s_in} <= 2'b11;
    else     {sync1, s_in} <= {ser_in, sync1};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_IDLE;
      cnt       <= '0;
      nbits     <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      pe_r      <= 1'b0;
      fe_r      <= 1'b0;
      wait_mark <= 1'b0;
    end else if (baud_tick) begin
      case (state)
        S_IDLE: begin
          // After a framing error a held-low (break) line must not look like a new start.
          if (wait_mark) begin
            if (s_in) wait_mark <= 1'b0;
          end else if (!s_in) begin
            cnt      <= HALF_CNT;
            nbits    <= '0;
            stop_idx <= 1'b0;
            pe_r     <= 1'b0;
            fe_r     <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (cnt != '0)   cnt <= cnt - CW'(1);
          else if (s_in)   state <= S_IDLE;
          else begin
            cnt   <= BIT_CNT;
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else begin
            shreg <= {s_in, shreg[DATA_BITS-1:1]};
            cnt   <= BIT_CNT;
            nbits <= nbits + 4'd1;
            if (nbits == 4'(DATA_BITS - 1)) state <= (PARITY != 0) ? S_PAR : S_STOP;
          end
        end
        S_PAR: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else begin
            pe_r  <= ((^shreg) ^ s_in) != (PARITY == 1);
            cnt   <= BIT_CNT;
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else if (push) begin
            wait_mark <= fe_now;
            state     <= S_IDLE;
          end else begin
            fe_r     <= fe_now;
            stop_idx <= 1'b1;
            cnt      <= BIT_CNT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign flag    = (count != '0);
  assign pop     = iot_sel & (iot_rd | iot_clr_flag) & flag;
  assign wr_en   = push & (~full | pop);
  assign ovr_set = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {shreg, fe_now, pe_r};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (clr)                        overrun <= 1'b0;
    else if (ovr_set)               overrun <= 1'b1;
    else if (iot_sel & iot_clr_err) overrun <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clr)                        reader_run <= 1'b0;
    else if (iot_sel & iot_rdr_run) reader_run <= 1'b1;
    else if (start_ok)              reader_run <= 1'b0;
  end

  assign head     = mem[rd_ptr];
  assign rd_gate  = iot_sel & iot_rd;
  assign data_out = (rd_gate & flag) ? head[WW-1:2] : '0;
  assign err_out  = rd_gate ? {head[1] & flag, head[0] & flag, overrun} : 3'b000;
  assign skip     = iot_sel & iot_skp & flag;
  assign active   = (state != S_IDLE);
endmodule

// File: tb/tb_tty_rx_fifo.sv
// Bench for tty_rx_fifo: an 8N2 instance and a 7E2 instance driven by directed frames.
// Reads push expected words into per-instance queues; a monitor compares whenever a read strobe is presented.
module tb_tty_rx_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, baud_tick, ser_a, ser_b, io_clr, sel_a, sel_b;
  logic iot_skp, iot_rd, iot_clr_flag, iot_clr_err, iot_rdr_run;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic [2:0] err_a, err_b;
  logic flag_a, skip_a, active_a, rr_a, ovr_a;
  logic flag_b, skip_b, active_b, rr_b, ovr_b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] e;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  tty_rx_fifo dut_a (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .ser_in(ser_a), .io_clr(io_clr),
    .iot_sel(sel_a), .iot_skp(iot_skp), .iot_rd(iot_rd), .iot_clr_flag(iot_clr_flag),
    .iot_clr_err(iot_clr_err), .iot_rdr_run(iot_rdr_run),
    .data_out(data_a), .err_out(err_a), .flag(flag_a), .skip(skip_a),
    .active(active_a), .reader_run(rr_a), .overrun(ovr_a)
  );

  tty_rx_fifo #(.DATA_BITS(7), .PARITY(2)) dut_b (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .ser_in(ser_b), .io_clr(io_clr),
    .iot_sel(sel_b), .iot_skp(iot_skp), .iot_rd(iot_rd), .iot_clr_flag(iot_clr_flag),
    .iot_clr_err(iot_clr_err), .iot_rdr_run(iot_rdr_run),
    .data_out(data_b), .err_out(err_b), .flag(flag_b), .skip(skip_b),
    .active(active_b), .reader_run(rr_b), .overrun(ovr_b)
  );

  // One baud_tick every 4 clocks, so a bit time is 32 clocks.
  initial begin
    baud_tick = 1'b0;
    forever begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        baud_tick = (i == 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Scoreboard monitor: runs after the stimulus of each cycle has settled.
  initial begin
    exp_t ex;
    forever begin
      @(negedge clk);
      #2;
      if (sel_a && iot_rd) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL read_a: got unexpected read data=%0h err=%b, required none queued", data_a, err_a);
        end else begin
          ex = qa.pop_front();
          if (data_a !== ex.d || err_a !== ex.e) begin
            errors++;
            $display("FAIL read_a: got data=%0h err=%b, required data=%0h err=%b", data_a, err_a, ex.d, ex.e);
          end
        end
      end
      if (sel_b && iot_rd) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL read_b: got unexpected read data=%0h err=%b, required none queued", data_b, err_b);
        end else begin
          ex = qb.pop_front();
          if ({1'b0, data_b} !== ex.d || err_b !== ex.e) begin
            errors++;
            $display("FAIL read_b: got data=%0h err=%b, required data=%0h err=%b", data_b, err_b, ex.d, ex.e);
          end
        end
      end
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic line_bit(input int w, input logic v);
    step;
    if (w == 0) ser_a = v;
    else        ser_b = v;
    repeat (31) step;
  endtask

  // Returns at the step whose following posedge carries a baud_tick.
  task automatic sync_tick;
    do step; while (!baud_tick);
  endtask

  task automatic send_frame(input int w, input logic [10:0] f);
    sync_tick;
    step;
    for (int i = 0; i < 11; i++) line_bit(w, f[i]);
  endtask

  task automatic read_a(input logic [7:0] d, input logic [2:0] e);
    exp_t x;
    step;
    x.d = d;
    x.e = e;
    qa.push_back(x);
    sel_a = 1'b1;
    iot_rd = 1'b1;
    step;
    sel_a = 1'b0;
    iot_rd = 1'b0;
  endtask

  task automatic read_b(input logic [7:0] d, input logic [2:0] e);
    exp_t x;
    step;
    x.d = d;
    x.e = e;
    qb.push_back(x);
    sel_b = 1'b1;
    iot_rd = 1'b1;
    step;
    sel_b = 1'b0;
    iot_rd = 1'b0;
  endtask

  task automatic pulse_rdr_run_a;
    step;
    sel_a = 1'b1;
    iot_rdr_run = 1'b1;
    step;
    sel_a = 1'b0;
    iot_rdr_run = 1'b0;
  endtask

  function automatic logic [10:0] f8(input logic [7:0] d);
    return {2'b11, d, 1'b0};
  endfunction

  function automatic logic [10:0] f7(input logic [6:0] d, input logic p, input logic [1:0] st);
    return {st, p, d, 1'b0};
  endfunction

  initial begin
    logic [10:0] fr;
    rst = 1'b1; io_clr = 1'b0; sel_a = 1'b0; sel_b = 1'b0;
    iot_skp = 1'b0; iot_rd = 1'b0; iot_clr_flag = 1'b0; iot_clr_err = 1'b0; iot_rdr_run = 1'b0;
    ser_a = 1'b1; ser_b = 1'b1;
    repeat (4) step;
    rst = 1'b0;
    step;

    chk1("rst_flag", flag_a, 1'b0);
    chk1("rst_overrun", ovr_a, 1'b0);
    chk1("rst_reader_run", rr_a, 1'b0);
    chk1("rst_active", active_a, 1'b0);
    chk1("rst_flag_b", flag_b, 1'b0);
    sel_a = 1'b1; iot_skp = 1'b1; #1;
    chk1("rst_skip", skip_a, 1'b0);
    sel_a = 1'b0; iot_skp = 1'b0;
    read_a(8'h00, 3'b000);

    // Reader run, then 8N2 frame 0x8D with cycle-exact start confirmation.
    pulse_rdr_run_a;
    chk1("rdr_run_set", rr_a, 1'b1);
    fr = f8(8'h8D);
    sync_tick;
    step;
    step;
    ser_a = fr[0];
    repeat (18) step;
    chk1("rdr_run_before_confirm", rr_a, 1'b1);
    step;
    chk1("rdr_run_after_confirm", rr_a, 1'b0);
    chk1("active_in_frame", active_a, 1'b1);
    repeat (12) step;
    for (int i = 1; i < 10; i++) line_bit(0, fr[i]);
    chk1("flag_before_stop2", flag_a, 1'b0);
    line_bit(0, fr[10]);
    chk1("flag_after_stop2", flag_a, 1'b1);
    read_a(8'h8D, 3'b000);
    chk1("flag_after_read", flag_a, 1'b0);

    // Three-tick glitch: false start.
    pulse_rdr_run_a;
    step;
    ser_a = 1'b0;
    repeat (12) step;
    ser_a = 1'b1;
    repeat (80) step;
    chk1("glitch_active", active_a, 1'b0);
    chk1("glitch_flag", flag_a, 1'b0);
    chk1("glitch_rdr_run", rr_a, 1'b1);

    // Five frames into a four-deep FIFO.
    for (int i = 0; i < 5; i++) send_frame(0, f8(8'(32'h41 + i)));
    chk1("overrun_set", ovr_a, 1'b1);
    chk1("overrun_flag", flag_a, 1'b1);
    for (int i = 0; i < 4; i++) read_a(8'(32'h41 + i), 3'b001);
    chk1("overrun_drained", flag_a, 1'b0);
    step;
    sel_a = 1'b1; iot_clr_err = 1'b1;
    step;
    sel_a = 1'b0; iot_clr_err = 1'b0;
    chk1("overrun_cleared", ovr_a, 1'b0);

    // io_clr in the middle of the data bits.
    sync_tick;
    step;
    for (int i = 0; i < 4; i++) line_bit(0, 1'b0);
    chk1("mid_data_active", active_a, 1'b1);
    step;
    io_clr = 1'b1;
    ser_a = 1'b1;
    step;
    io_clr = 1'b0;
    chk1("io_clr_active", active_a, 1'b0);
    chk1("io_clr_flag", flag_a, 1'b0);
    repeat (400) step;
    chk1("io_clr_no_push", flag_a, 1'b0);
    chk1("io_clr_idle", active_a, 1'b0);

    // Full FIFO; fifth push lands on the same edge as a read.
    for (int i = 0; i < 4; i++) send_frame(0, f8(8'(32'h10 + i)));
    chk1("full_flag", flag_a, 1'b1);
    chk1("full_no_overrun", ovr_a, 1'b0);
    fr = f8(8'h14);
    sync_tick;
    step;
    for (int i = 0; i < 10; i++) line_bit(0, fr[i]);
    step;
    ser_a = fr[10];
    repeat (17) step;
    read_a(8'h10, 3'b000);
    chk1("coincide_no_overrun", ovr_a, 1'b0);
    chk1("coincide_flag", flag_a, 1'b1);
    sel_a = 1'b1; iot_skp = 1'b1; #1;
    chk1("skip_on", skip_a, 1'b1);
    iot_skp = 1'b0; #1;
    chk1("skip_no_strobe", skip_a, 1'b0);
    sel_a = 1'b0; iot_skp = 1'b1; #1;
    chk1("skip_no_sel", skip_a, 1'b0);
    iot_skp = 1'b0;
    repeat (20) step;
    for (int i = 0; i < 4; i++) read_a(8'(32'h11 + i), 3'b000);
    chk1("coincide_count4", flag_a, 1'b0);

    // 7E2: wrong parity, then framing error held as break, then a clean word.
    send_frame(1, f7(7'h43, 1'b0, 2'b11));
    chk1("par_flag", flag_b, 1'b1);
    read_b(8'h43, 3'b010);
    chk1("par_drained", flag_b, 1'b0);
    send_frame(1, f7(7'h43, 1'b1, 2'b00));
    repeat (448) step;
    chk1("break_flag", flag_b, 1'b1);
    chk1("break_idle", active_b, 1'b0);
    step;
    ser_b = 1'b1;
    repeat (64) step;
    read_b(8'h43, 3'b100);
    chk1("break_single_word", flag_b, 1'b0);
    send_frame(1, f7(7'h55, 1'b0, 2'b11));
    read_b(8'h55, 3'b000);
    chk1("after_break_drained", flag_b, 1'b0);

    repeat (4) step;
    chk8("queue_a_empty", 8'(qa.size()), 8'd0);
    chk8("queue_b_empty", 8'(qb.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
